// File: rtl/systolic_result_drain_pkg.sv
// Shared definitions for the systolic result drain.
//   state_t   : CAPTURE collects PE results, DRAIN streams them out.
//   IDX_BITS  : drain index width for the default 4x4 array.
//   idx_width : drain index width for any array side length.
//   row_of / col_of : split a row-major index into row and column.
package systolic_pkg;

  typedef enum logic {
    CAPTURE = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  localparam int DEFAULT_DIMENSION = 4;
  localparam int IDX_BITS = $clog2(DEFAULT_DIMENSION * DEFAULT_DIMENSION);

  function automatic int idx_width(input int dim);
    return $clog2(dim * dim);
  endfunction

  function automatic int row_of(input int idx, input int dim);
    return idx / dim;
  endfunction

  function automatic int col_of(input int idx, input int dim);
    return idx % dim;
  endfunction

endpackage

// File: rtl/systolic_result_drain_if.sv
// Result stream from the drain block to the downstream consumer.
//   o_data  : result word
//   o_valid : o_data/o_row/o_col/o_last are valid
//   i_ready : consumer accepts the word this cycle
//   o_row, o_col : position of the word in the result matrix
//   o_last  : word is the bottom-right PE
interface systolic_result_drain_if #(
  parameter int O_BITS  = 18,
  parameter int RC_BITS = 2
);
  logic [O_BITS-1:0]  o_data;
  logic               o_valid;
  logic               i_ready;
  logic [RC_BITS-1:0] o_row;
  logic [RC_BITS-1:0] o_col;
  logic               o_last;

  modport master (
    output o_data, o_valid, o_row, o_col, o_last,
    input  i_ready
  );

  modport slave (
    input  o_data, o_valid, o_row, o_col, o_last,
    output i_ready
  );
endinterface

// File: rtl/systolic_result_drain_counter.sv
// Drain index register for the result stream.
//   i_clock, i_reset : clock and synchronous active-high reset
//   i_clear   : force the index back to 0 (drain start / drain end)
//   i_advance : a word was accepted; step to the next index
//   o_index   : current row-major index
//   o_row, o_col : index split into matrix position
//   o_last    : index is the final word of the matrix
module systolic_drain_counter
  import systolic_pkg::*;
#(
  parameter int DIMENSION = 4,
  localparam int IDX_W = idx_width(DIMENSION),
  localparam int RC_W  = $clog2(DIMENSION)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_advance,
  output logic [IDX_W-1:0] o_index,
  output logic [RC_W-1:0]  o_row,
  output logic [RC_W-1:0]  o_col,
  output logic             o_last
);

  localparam int LAST_IDX = DIMENSION * DIMENSION - 1;

  logic [IDX_W-1:0] index_q;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      index_q <= '0;
    end else if (i_advance) begin
      index_q <= index_q + 1'b1;
    end
  end

  assign o_index = index_q;
  assign o_row   = RC_W'(row_of(int'(index_q), DIMENSION));
  assign o_col   = RC_W'(col_of(int'(index_q), DIMENSION));
  assign o_last  = (index_q == IDX_W'(LAST_IDX));

endmodule

// File: rtl/systolic_result_drain.sv
// Captures each PE result in its finish cycle and, once every PE has
// reported, streams the matrix out in row-major order.
//   i_clock, i_reset : clock and synchronous active-high reset
//   i_c_flat         : PE results, PE(r,c) in slice r*DIMENSION+c
//   i_finish_flat    : one-cycle per-PE finish flags, same mapping
//   drain            : result stream (master side)
//   o_busy           : high while draining
//   o_overrun        : sticky; a finish arrived twice or during drain
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int DIMENSION = 4,
  parameter int I_BITS    = 8,
  parameter int O_BITS    = (I_BITS * 2) + $clog2(DIMENSION)
) (
  input  logic                                 i_clock,
  input  logic                                 i_reset,
  input  logic [DIMENSION*DIMENSION*O_BITS-1:0] i_c_flat,
  input  logic [DIMENSION*DIMENSION-1:0]        i_finish_flat,
  systolic_result_drain_if.master              drain,
  output logic                                 o_busy,
  output logic                                 o_overrun
);

  localparam int N     = DIMENSION * DIMENSION;
  localparam int IDX_W = idx_width(DIMENSION);
  localparam int RC_W  = $clog2(DIMENSION);

  state_t            state;
  logic [N-1:0]      mask;
  logic [O_BITS-1:0] bank [N];
  logic              overrun_q;

  logic [N-1:0]      mask_next;
  logic              handshake;
  logic              ctr_clear;
  logic [IDX_W-1:0]  index;
  logic [RC_W-1:0]   row;
  logic [RC_W-1:0]   col;
  logic              last;

  assign mask_next = mask | i_finish_flat;
  assign handshake = (state == DRAIN) && drain.i_ready;
  // Clearing on entry keeps index 0 ready for the first word; clearing on
  // the final handshake stops the increment from wrapping past the end.
  assign ctr_clear = ((state == CAPTURE) && (&mask_next)) || (handshake && last);

  systolic_drain_counter #(
    .DIMENSION (DIMENSION)
  ) u_counter (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (ctr_clear),
    .i_advance (handshake),
    .o_index   (index),
    .o_row     (row),
    .o_col     (col),
    .o_last    (last)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= CAPTURE;
      mask      <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        bank[i] <= '0;
      end
    end else begin
      case (state)
        CAPTURE: begin
          // First finish wins; a repeat keeps the stored value.
          for (int i = 0; i < N; i++) begin
            if (i_finish_flat[i] && !mask[i]) begin
              bank[i] <= i_c_flat[i*O_BITS +: O_BITS];
            end
          end
          if (|(i_finish_flat & mask)) begin
            overrun_q <= 1'b1;
          end
          mask <= mask_next;
          if (&mask_next) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (|i_finish_flat) begin
            overrun_q <= 1'b1;
          end
          if (handshake && last) begin
            state <= CAPTURE;
            mask  <= '0;
          end
        end
        default: state <= CAPTURE;
      endcase
    end
  end

  assign o_busy        = (state == DRAIN);
  assign o_overrun     = overrun_q;
  assign drain.o_valid = o_busy;
  assign drain.o_data  = o_busy ? bank[index] : '0;
  assign drain.o_row   = o_busy ? row : '0;
  assign drain.o_col   = o_busy ? col : '0;
  assign drain.o_last  = o_busy && last;

endmodule

// File: tb/tb_systolic_result_drain.sv
module tb_systolic_result_drain;

  localparam int DIM = 4;
  localparam int N   = DIM * DIM;
  localparam int OB  = 18;

  logic              i_clock = 1'b0;
  logic              i_reset = 1'b1;
  logic [N*OB-1:0]   i_c_flat = '0;
  logic [N-1:0]      i_finish_flat = '0;
  logic              o_busy;
  logic              o_overrun;

  int tests_run = 0;
  int tests_failed = 0;

  systolic_result_drain_if #(.O_BITS(OB), .RC_BITS(2)) bus ();

  systolic_result_drain #(.DIMENSION(DIM), .I_BITS(8), .O_BITS(OB)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_c_flat      (i_c_flat),
    .i_finish_flat (i_finish_flat),
    .drain         (bus.master),
    .o_busy        (o_busy),
    .o_overrun     (o_overrun)
  );

  always #5 i_clock = ~i_clock;

  // Reference model: what the matrix should hold, which PEs have reported,
  // whether a drain is pending, and whether a protocol error has occurred.
  logic [OB-1:0] drive_val [N];
  logic [OB-1:0] m_bank [N];
  logic [N-1:0]  m_mask;
  bit            m_drain;
  bit            m_overrun;

  logic [OB-1:0] got_data [$];
  int            got_row [$];
  int            got_col [$];
  bit            got_last [$];

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_bank[i] = '0;
    m_mask = '0;
    m_drain = 0;
    m_overrun = 0;
  endtask

  task automatic rand_vals();
    for (int i = 0; i < N; i++) drive_val[i] = OB'($urandom);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_finish_flat = '0;
    bus.i_ready = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
    model_clear();
  endtask

  // Present drive_val with the given finish flags for one cycle.
  task automatic pulse(input logic [N-1:0] flags);
    for (int i = 0; i < N; i++) i_c_flat[i*OB +: OB] = drive_val[i];
    i_finish_flat = flags;
    for (int i = 0; i < N; i++) begin
      if (flags[i]) begin
        if (m_drain || m_mask[i]) m_overrun = 1;
        else begin
          m_bank[i] = drive_val[i];
          m_mask[i] = 1'b1;
        end
      end
    end
    if (!m_drain && (&m_mask)) m_drain = 1;
    tick();
    i_finish_flat = '0;
    for (int i = 0; i < N; i++) i_c_flat[i*OB +: OB] = OB'($urandom);
  endtask

  task automatic capture_random();
    logic [N-1:0] rem;
    logic [N-1:0] f;
    int guard;
    rem = '1;
    guard = 0;
    while (rem != '0) begin
      f = (guard > 40) ? rem : (rem & N'($urandom));
      pulse(f);
      rem = rem & ~f;
      guard++;
    end
  endtask

  // Consumer: mode 0 always ready, 1 = ready pattern 1,0,0, 2 = random.
  task automatic collect(input int mode, input int max_words, output int n,
                         output int steps, output int hold_err, output bit timeout);
    logic [OB-1:0] pd;
    logic [1:0] pr, pc;
    logic pl;
    bit stalled, done, r;
    got_data.delete(); got_row.delete(); got_col.delete(); got_last.delete();
    n = 0; steps = 0; hold_err = 0; timeout = 0; stalled = 0;
    pd = '0; pr = '0; pc = '0; pl = 1'b0;
    forever begin
      if (steps >= 400) begin timeout = 1; break; end
      if (stalled && (bus.o_valid !== 1'b1 || bus.o_data !== pd || bus.o_row !== pr ||
                      bus.o_col !== pc || bus.o_last !== pl)) hold_err++;
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (steps % 3 == 0) : 1'($urandom_range(0, 1));
      bus.i_ready = r;
      done = 0;
      if (bus.o_valid === 1'b1 && r) begin
        got_data.push_back(bus.o_data);
        got_row.push_back(int'(bus.o_row));
        got_col.push_back(int'(bus.o_col));
        got_last.push_back(bus.o_last === 1'b1);
        n++;
        if (bus.o_last === 1'b1) begin
          m_drain = 0;
          m_mask = '0;
          done = 1;
        end
        if (n >= max_words) done = 1;
      end
      stalled = (bus.o_valid === 1'b1) && !r;
      pd = bus.o_data; pr = bus.o_row; pc = bus.o_col; pl = bus.o_last;
      tick();
      steps++;
      if (done) break;
    end
    bus.i_ready = 1'b0;
  endtask

  // Word-by-word check of the collected stream against the model.
  // Inlined per test via this macro-free loop body kept in each test.

  task automatic test_reset();
    i_reset = 1'b1;
    i_finish_flat = '1;
    bus.i_ready = 1'b1;
    tick();
    tests_run++;
    if ({bus.o_valid, o_busy, bus.o_last, o_overrun} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000", {bus.o_valid, o_busy, bus.o_last, o_overrun});
    end
    tests_run++;
    if ({bus.o_data, bus.o_row, bus.o_col} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got data=%0d row=%0d col=%0d expected 0", bus.o_data, bus.o_row, bus.o_col);
    end
    i_finish_flat = '0;
    bus.i_ready = 1'b0;
    i_reset = 1'b0;
    model_clear();
    tick();
    tests_run++;
    if (bus.o_valid !== 1'b0 || o_overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mask_clear: got valid=%b overrun=%b expected 0 0", bus.o_valid, o_overrun);
    end
  endtask

  task automatic anti_diagonal_capture(input bit fixed_vals);
    logic [N-1:0] f;
    for (int k = 0; k <= 16; k++) begin
      f = '0;
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++)
          if (10 + r + c == k) begin
            f[r*DIM+c] = 1'b1;
            drive_val[r*DIM+c] = fixed_vals ? OB'(100*r + c) : OB'($urandom);
          end
      if (k == 16) begin
        tests_run++;
        if (bus.o_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL diag_early_valid: got %b expected 0 in cycle 16", bus.o_valid);
        end
      end
      pulse(f);
    end
  endtask

  task automatic test_anti_diagonal();
    int n, steps, herr, bad;
    bit to;
    do_reset();
    anti_diagonal_capture(1);
    tests_run++;
    if (bus.o_valid !== 1'b1 || o_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL diag_valid_17: got valid=%b busy=%b expected 1 1", bus.o_valid, o_busy);
    end
    collect(0, N, n, steps, herr, to);
    tests_run++;
    if (to || n != N || steps != N) begin
      tests_failed++;
      $display("FAIL diag_count: got words=%0d cycles=%0d expected %0d %0d", n, steps, N, N);
    end
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (got_data[i] !== OB'(100*(i/DIM) + i%DIM) || got_data[i] !== m_bank[i] ||
          got_row[i] != i/DIM || got_col[i] != i%DIM || got_last[i] != (i == N-1)) begin
        bad++;
        $display("FAIL diag_word %0d: got %0d r%0d c%0d l%0d expected %0d", i, got_data[i],
                 got_row[i], got_col[i], got_last[i], 100*(i/DIM) + i%DIM);
      end
    end
    tests_run++;
    if (bad != 0) tests_failed++;
    tests_run++;
    if (o_overrun !== 1'b0 || bus.o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL diag_after: got overrun=%b valid=%b expected 0 0", o_overrun, bus.o_valid);
    end
  endtask

  task automatic test_backpressure();
    int n, steps, herr, bad;
    bit to;
    do_reset();
    anti_diagonal_capture(0);
    collect(1, N, n, steps, herr, to);
    tests_run++;
    if (to || n != N || herr != 0) begin
      tests_failed++;
      $display("FAIL bp_stream: got words=%0d hold_errs=%0d timeout=%0d expected %0d 0 0", n, herr, to, N);
    end
    bad = 0;
    for (int i = 0; i < n; i++)
      if (got_data[i] !== m_bank[i] || got_row[i] != i/DIM || got_col[i] != i%DIM) begin
        bad++;
        $display("FAIL bp_word %0d: got %0d expected %0d", i, got_data[i], m_bank[i]);
      end
    tests_run++;
    if (bad != 0) tests_failed++;
  endtask

  task automatic test_all_at_once();
    int n, steps, herr, bad;
    bit to;
    do_reset();
    rand_vals();
    tests_run++;
    if (bus.o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL all_pre_valid: got %b expected 0", bus.o_valid);
    end
    pulse('1);
    tests_run++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== m_bank[0]) begin
      tests_failed++;
      $display("FAIL all_valid_t1: got valid=%b data=%0d expected 1 %0d", bus.o_valid, bus.o_data, m_bank[0]);
    end
    collect(2, N, n, steps, herr, to);
    bad = (to || n != N || herr != 0) ? 1 : 0;
    for (int i = 0; i < n; i++)
      if (got_data[i] !== m_bank[i] || got_last[i] != (i == N-1)) begin
        bad++;
        $display("FAIL all_word %0d: got %0d expected %0d", i, got_data[i], m_bank[i]);
      end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL all_stream: got %0d words, %0d errors expected %0d words, 0 errors", n, bad, N);
    end
  endtask

  // Capture accepted in the cycle right after the final handshake.
  task automatic test_back_to_back();
    int n, steps, herr, bad;
    bit to;
    rand_vals();
    pulse('1);
    tests_run++;
    if (bus.o_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_valid: got %b expected 1", bus.o_valid);
    end
    collect(0, N, n, steps, herr, to);
    bad = (to || n != N) ? 1 : 0;
    for (int i = 0; i < n; i++) if (got_data[i] !== m_bank[i]) bad++;
    tests_run++;
    if (bad != 0 || o_overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_stream: got errors=%0d overrun=%b expected 0 0", bad, o_overrun);
    end
  endtask

  task automatic test_duplicate();
    int n, steps, herr, bad;
    bit to;
    do_reset();
    rand_vals();
    drive_val[6] = OB'(5);
    pulse(N'(1) << 6);
    tests_run++;
    if (o_overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL dup_first_clean: got overrun=%b expected 0", o_overrun);
    end
    drive_val[6] = OB'(9);
    pulse(N'(1) << 6);
    tests_run++;
    if (o_overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL dup_overrun: got %b expected 1", o_overrun);
    end
    pulse(~(N'(1) << 6));
    collect(0, N, n, steps, herr, to);
    tests_run++;
    if (n != N || got_data[6] !== OB'(5)) begin
      tests_failed++;
      $display("FAIL dup_word6: got %0d expected 5", (n > 6) ? int'(got_data[6]) : -1);
    end
    bad = 0;
    for (int i = 0; i < n; i++) if (got_data[i] !== m_bank[i]) bad++;
    tests_run++;
    if (bad != 0 || o_overrun !== m_overrun) begin
      tests_failed++;
      $display("FAIL dup_stream: got errors=%0d overrun=%b expected 0 %b", bad, o_overrun, m_overrun);
    end
  endtask

  task automatic test_finish_during_drain();
    int n, steps, herr, bad;
    bit to;
    do_reset();
    rand_vals();
    pulse('1);
    tick();
    drive_val[0] = OB'(77);
    pulse(N'(1));
    tests_run++;
    if (o_overrun !== 1'b1 || bus.o_data !== m_bank[0]) begin
      tests_failed++;
      $display("FAIL fdd_overrun: got overrun=%b data=%0d expected 1 %0d", o_overrun, bus.o_data, m_bank[0]);
    end
    collect(0, N, n, steps, herr, to);
    bad = (to || n != N) ? 1 : 0;
    for (int i = 0; i < n; i++) if (got_data[i] !== m_bank[i]) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL fdd_stream: got %0d errors expected 0 (word0 %0d vs %0d)", bad,
               (n > 0) ? int'(got_data[0]) : -1, m_bank[0]);
    end
    rand_vals();
    pulse(~(N'(1) << 15));
    tick();
    tests_run++;
    if (bus.o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fdd_needs_all: got valid=%b expected 0 with 15 finishes", bus.o_valid);
    end
    pulse(N'(1) << 15);
    tests_run++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== m_bank[0]) begin
      tests_failed++;
      $display("FAIL fdd_recapture: got valid=%b data=%0d expected 1 %0d", bus.o_valid, bus.o_data, m_bank[0]);
    end
    collect(0, N, n, steps, herr, to);
  endtask

  task automatic test_reset_mid_drain();
    int n, steps, herr, bad;
    bit to;
    do_reset();
    rand_vals();
    pulse('1);
    collect(0, 5, n, steps, herr, to);
    tests_run++;
    if (n != 5 || bus.o_row !== 2'd1 || bus.o_col !== 2'd1) begin
      tests_failed++;
      $display("FAIL rmd_partial: got words=%0d row=%0d col=%0d expected 5 1 1", n, bus.o_row, bus.o_col);
    end
    i_reset = 1'b1;
    tick();
    tests_run++;
    if ({bus.o_valid, o_busy, bus.o_last, o_overrun} !== 4'b0 ||
        {bus.o_data, bus.o_row, bus.o_col} !== '0) begin
      tests_failed++;
      $display("FAIL rmd_reset_vals: got valid=%b busy=%b data=%0d row=%0d col=%0d expected all 0",
               bus.o_valid, o_busy, bus.o_data, bus.o_row, bus.o_col);
    end
    i_reset = 1'b0;
    model_clear();
    rand_vals();
    capture_random();
    collect(2, N, n, steps, herr, to);
    bad = (to || n != N || herr != 0) ? 1 : 0;
    for (int i = 0; i < n; i++)
      if (got_data[i] !== m_bank[i] || got_row[i] != i/DIM || got_col[i] != i%DIM ||
          got_last[i] != (i == N-1)) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL rmd_fresh_stream: got %0d errors over %0d words expected 0 over %0d", bad, n, N);
    end
  endtask

  initial begin
    model_clear();
    bus.i_ready = 1'b0;
    for (int i = 0; i < N; i++) drive_val[i] = '0;
    test_reset();
    test_anti_diagonal();
    test_backpressure();
    test_all_at_once();
    test_back_to_back();
    test_duplicate();
    test_finish_during_drain();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
